// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a byte-addressed data memory.
// Takes one request at a time, checks range and natural alignment, issues a
// single-cycle read or write strobe, extends load data and returns a response.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_write, req_size,        request attributes (size: 00 word, 01 half,
//   req_unsigned, req_addr,     10 byte, 11 double), store data right-aligned
//   req_wdata
//   rsp_valid/rsp_ready         response handshake
//   rsp_data                    extended load data, 0 for stores and faults
//   rsp_misaligned, rsp_oob     fault flags
//   mem_write, mem_read         single-cycle memory strobes
//   mem_size, mem_addr,         memory access attributes, held between accesses
//   mem_wdata
//   mem_rdata                   memory read data, valid the cycle after mem_read
module mem_access_unit #(
    parameter int unsigned MEM_BYTES   = 88,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_misaligned,
    output logic        rsp_oob,
    output logic        mem_write,
    output logic        mem_read,
    output logic [1:0]  mem_size,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned AW = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;

    logic        lat_write;
    logic        lat_unsigned;

    logic [3:0]    nbytes;
    logic [2:0]    align_mask;
    logic [AW:0]   end_addr;
    logic          oob_fault;
    logic          mis_fault;
    logic [AW-1:0] ext_data;

    // Request checks; the end address is one bit wider so it cannot wrap.
    always_comb begin
        case (req_size)
            2'b00:   nbytes = 4'd4;
            2'b01:   nbytes = 4'd2;
            2'b10:   nbytes = 4'd1;
            default: nbytes = 4'd8;
        endcase
        align_mask = 3'(nbytes - 4'd1);
        end_addr   = {1'b0, req_addr} + (AW+1)'(nbytes);
        oob_fault  = end_addr > (AW+1)'(MEM_BYTES);
        mis_fault  = CHECK_ALIGN && ((req_addr[2:0] & align_mask) != 3'd0);
    end

    // Load result extension; mem_size still holds the size of the access.
    always_comb begin
        case (mem_size)
            2'b10:   ext_data = lat_unsigned ? {56'd0, mem_rdata[7:0]}
                                             : {{56{mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01:   ext_data = lat_unsigned ? {48'd0, mem_rdata[15:0]}
                                             : {{48{mem_rdata[15]}}, mem_rdata[15:0]};
            2'b00:   ext_data = lat_unsigned ? {32'd0, mem_rdata[31:0]}
                                             : {{32{mem_rdata[31]}}, mem_rdata[31:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    // Sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_misaligned <= 1'b0;
            rsp_oob        <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_size       <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            lat_write      <= 1'b0;
            lat_unsigned   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        lat_write    <= req_write;
                        lat_unsigned <= req_unsigned;
                        if (oob_fault || mis_fault) begin
                            // Faulting requests never reach the memory bus.
                            state          <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_data       <= '0;
                            rsp_oob        <= oob_fault;
                            rsp_misaligned <= mis_fault;
                        end else begin
                            state     <= ACCESS;
                            mem_write <= req_write;
                            mem_read  <= !req_write;
                            mem_size  <= req_size;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    if (lat_write) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= ext_data;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state          <= IDLE;
                        rsp_valid      <= 1'b0;
                        rsp_data       <= '0;
                        rsp_misaligned <= 1'b0;
                        rsp_oob        <= 1'b0;
                        req_ready      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized requests checked
// against a byte-array reference model of the data memory.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 88;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_misaligned, rsp_oob;
    logic [63:0] rsp_data;
    logic        mem_write, mem_read;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic        req_valid2, req_ready2, rsp_valid2, rsp_misaligned2, rsp_oob2;
    logic [63:0] rsp_data2;
    logic        mem_write2, mem_read2;
    logic [1:0]  mem_size2;
    logic [63:0] mem_addr2, mem_wdata2, mem_rdata2;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES), .CHECK_ALIGN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned), .rsp_oob(rsp_oob),
        .mem_write(mem_write), .mem_read(mem_read), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.MEM_BYTES(MEM_BYTES), .CHECK_ALIGN(1'b0)) u_dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .rsp_misaligned(rsp_misaligned2), .rsp_oob(rsp_oob2),
        .mem_write(mem_write2), .mem_read(mem_read2), .mem_size(mem_size2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
    );

    function automatic int nb(input logic [1:0] s);
        case (s)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 8;
        endcase
    endfunction

    // Little-endian data memory seen by the main DUT; cleared while in reset.
    logic [7:0]  mem [MEM_BYTES];
    logic [63:0] rd_tmp;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'd0;
            mem_rdata <= 64'd0;
        end else begin
            if (mem_write)
                for (int i = 0; i < nb(mem_size); i++)
                    if ((mem_addr + 64'(i)) < 64'(MEM_BYTES))
                        mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
            if (mem_read) begin
                rd_tmp = 64'd0;
                for (int i = 0; i < nb(mem_size); i++)
                    if ((mem_addr + 64'(i)) < 64'(MEM_BYTES))
                        rd_tmp[8*i +: 8] = mem[int'(mem_addr) + i];
                mem_rdata <= rd_tmp;
            end
        end
    end

    // The unchecked-alignment instance reads a fixed pattern.
    always @(posedge clk) begin
        if (!rst_n) mem_rdata2 <= 64'd0;
        else if (mem_read2) mem_rdata2 <= 64'h0123456789ABCDEF;
    end

    // Strobe monitor: one count per cycle a strobe is high.
    int          wr_cnt = 0, rd_cnt = 0, cnt2 = 0;
    logic [63:0] s_addr, s_wdata, s_addr2, s_wdata2;
    logic [1:0]  s_size, s_size2;
    always @(negedge clk) begin
        if (mem_write) begin
            wr_cnt++; s_addr = mem_addr; s_size = mem_size; s_wdata = mem_wdata;
        end
        if (mem_read) begin
            rd_cnt++; s_addr = mem_addr; s_size = mem_size;
        end
        if (mem_write2 || mem_read2) begin
            cnt2++; s_addr2 = mem_addr2; s_size2 = mem_size2; s_wdata2 = mem_wdata2;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state and per-transaction expectations.
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [63:0] exp_data, exp_addr, exp_wdata;
    logic [1:0]  exp_size;
    logic        exp_mis, exp_oob;
    int          exp_lat, exp_wr, exp_rd;
    int          snap_wr, snap_rd;
    logic [63:0] last_data;
    logic        last_mis, last_oob;

    task automatic clear_ref();
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'd0;
    endtask

    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd);
        int n;
        n         = nb(sz);
        exp_oob   = ({1'b0, a} + 65'(n)) > 65'(MEM_BYTES);
        exp_mis   = (a % 64'(n)) != 64'd0;
        exp_data  = 64'd0;
        exp_wr    = 0;
        exp_rd    = 0;
        exp_addr  = a;
        exp_size  = sz;
        exp_wdata = wd;
        if (exp_oob || exp_mis) begin
            exp_lat = 1;
        end else if (w) begin
            exp_lat = 2;
            exp_wr  = 1;
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            exp_lat = 3;
            exp_rd  = 1;
            for (int i = 0; i < n; i++)
                exp_data = exp_data + (64'(ref_mem[int'(a) + i]) << (8*i));
            if (!u && n < 8 && exp_data[8*n-1])
                exp_data = exp_data - (64'd1 << (8*n));
        end
    endtask

    // Present a request and return just after its accept edge.
    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd);
        int k;
        k            = 0;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("req_ready_before_accept", 64'(req_ready), 64'd1);
        snap_wr = wr_cnt;
        snap_rd = rd_cnt;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
    endtask

    // Wait for the response, hold it for 'delay' cycles, then hand it off.
    task automatic wait_rsp(input int delay);
        int k;
        k = 1;
        while (!rsp_valid && k < 10) begin
            @(posedge clk); #1; k++;
        end
        check("latency", 64'(k), 64'(exp_lat));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_misaligned", 64'(rsp_misaligned), 64'(exp_mis));
        check("rsp_oob", 64'(rsp_oob), 64'(exp_oob));
        last_data = rsp_data;
        last_mis  = rsp_misaligned;
        last_oob  = rsp_oob;
        repeat (delay) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_data", rsp_data, exp_data);
            check("hold_flags", 64'({rsp_misaligned, rsp_oob}), 64'({exp_mis, exp_oob}));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_req_ready", 64'(req_ready), 64'd1);
        check("post_rsp_data", rsp_data, 64'd0);
        check("post_flags", 64'({rsp_misaligned, rsp_oob}), 64'd0);
        check("write_pulses", 64'(wr_cnt - snap_wr), 64'(exp_wr));
        check("read_pulses", 64'(rd_cnt - snap_rd), 64'(exp_rd));
        if (exp_wr + exp_rd > 0) begin
            check("strobe_addr", s_addr, exp_addr);
            check("strobe_size", 64'(s_size), 64'(exp_size));
        end
        if (exp_wr > 0) check("strobe_wdata", s_wdata, exp_wdata);
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd, input int delay);
        model(w, sz, u, a, wd);
        send(w, sz, u, a, wd);
        wait_rsp(delay);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [1:0]  sz;
        logic [63:0] a;

        rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; rsp_ready = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        clear_ref();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_strobes", 64'({mem_write, mem_read}), 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        check("reset_mem_addr", mem_addr, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store then loads of each width.
        txn(1'b1, 2'b11, 1'b0, 64'h08, 64'h8877665544332211, 0);
        check("st_strobe_size", 64'(s_size), 64'd3);
        check("st_strobe_addr", s_addr, 64'h08);
        txn(1'b0, 2'b10, 1'b0, 64'h0F, 64'd0, 1);
        check("ld_byte_signed", last_data, 64'hFFFFFFFFFFFFFF88);
        txn(1'b0, 2'b01, 1'b1, 64'h0E, 64'd0, 0);
        check("ld_half_unsigned", last_data, 64'h0000000000008877);
        txn(1'b0, 2'b00, 1'b0, 64'h0C, 64'd0, 2);
        check("ld_word_signed", last_data, 64'hFFFFFFFF88776655);
        txn(1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 0);
        check("ld_double", last_data, 64'h8877665544332211);

        // Faults and range boundaries.
        txn(1'b0, 2'b00, 1'b0, 64'h0A, 64'd0, 0);
        check("misal_word_flags", 64'({last_mis, last_oob}), 64'b10);
        txn(1'b0, 2'b11, 1'b0, 64'h50, 64'd0, 0);
        check("dbl_0x50_flags", 64'({last_mis, last_oob}), 64'b00);
        txn(1'b0, 2'b11, 1'b0, 64'h51, 64'd0, 0);
        check("dbl_0x51_flags", 64'({last_mis, last_oob}), 64'b11);
        txn(1'b0, 2'b10, 1'b0, 64'h58, 64'd0, 0);
        check("byte_0x58_flags", 64'({last_mis, last_oob}), 64'b01);
        txn(1'b1, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h1234, 1);
        check("wrap_flags", 64'({last_mis, last_oob}), 64'b01);

        // Back-to-back: second request waits with req_valid high through the response.
        model(1'b0, 2'b00, 1'b0, 64'h0C, 64'd0);
        send(1'b0, 2'b00, 1'b0, 64'h0C, 64'd0);
        req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 64'h20; req_wdata = 64'hA5A5; req_valid = 1'b1;
        wait_rsp(4);
        txn(1'b1, 2'b01, 1'b0, 64'h20, 64'hA5A5, 0);
        txn(1'b0, 2'b01, 1'b0, 64'h20, 64'd0, 0);
        check("b2b_readback", last_data, 64'hFFFFFFFFFFFFA5A5);

        // Misaligned word with alignment checking disabled.
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 64'h0A;
        snap_wr = cnt2;
        req_valid2 = 1'b1;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        k = 1;
        while (!rsp_valid2 && k < 10) begin
            @(posedge clk); #1; k++;
        end
        check("na_latency", 64'(k), 64'd3);
        check("na_rsp_data", rsp_data2, 64'hFFFFFFFF89ABCDEF);
        check("na_flags", 64'({rsp_misaligned2, rsp_oob2}), 64'd0);
        check("na_strobes", 64'(cnt2 - snap_wr), 64'd1);
        check("na_strobe_addr", s_addr2, 64'h0A);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("na_post_valid", 64'(rsp_valid2), 64'd0);

        // Reset in the middle of a store's access cycle.
        send(1'b1, 2'b11, 1'b0, 64'h30, 64'hDEADBEEFCAFEF00D);
        check("rst_pre_write", 64'(mem_write), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_write_drop", 64'(mem_write), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        clear_ref();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("rst_no_response", 64'(rsp_valid), 64'd0);
        end
        txn(1'b0, 2'b11, 1'b0, 64'h30, 64'd0, 0);
        check("rst_store_dropped", last_data, 64'd0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom);
            if ($urandom_range(0, 9) < 8) a = 64'($urandom_range(0, 95));
            else a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = a & ~(64'(nb(sz)) - 64'd1);
            txn(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
                int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
